// File: rtl/vend_pkg.sv
// vend_pkg: coin/state types, coin values in nickel units and a value lookup helper
package vend_pkg;
  typedef enum logic [1:0] {NICKEL, DIME, QUARTER, HALF} coin_t;
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  localparam logic [3:0] NICKEL_V  = 4'd1;
  localparam logic [3:0] DIME_V    = 4'd2;
  localparam logic [3:0] QUARTER_V = 4'd5;
  localparam logic [3:0] HALF_V    = 4'd10;
  function automatic logic [3:0] coin_value(coin_t c);
    return c == HALF ? HALF_V : c == QUARTER ? QUARTER_V : c == DIME ? DIME_V : NICKEL_V;
  endfunction
endpackage

// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: coin-tube inventory, remaining-change register and greedy coin ejector
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W     = 7,
  parameter int TUBE_W       = 4,
  parameter int INIT_TUBE    = 8,
  parameter int EXACT_THRESH = 2
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                start_i,
  input  logic [CREDIT_W-1:0] amount_i,
  input  logic                active_i,
  input  logic                dep_valid_i,
  input  logic [1:0]          dep_type_i,
  output logic                pending_o,
  output logic                coin_out_valid_o,
  output logic [1:0]          coin_out_type_o,
  output logic                done_o,
  output logic                short_o,
  output logic                exact_change_only_o
);
  localparam logic [TUBE_W-1:0] TUBE_FULL = '1;
  localparam logic [TUBE_W-1:0] TUBE_INIT = TUBE_W'(INIT_TUBE);
  localparam logic [TUBE_W-1:0] THRESH    = TUBE_W'(EXACT_THRESH);
  logic [TUBE_W-1:0]   tube_q [4];
  logic [TUBE_W-1:0]   tube_d [4];
  logic [CREDIT_W-1:0] rem_q, rem_d, pay;
  logic                found;
  coin_t               pick;
  // ascending scan: the last qualifying denomination is the largest one
  always_comb begin
    found = 1'b0;
    pick  = NICKEL;
    for (int i = 0; i < 4; i++)
      if (tube_q[i] != '0 && CREDIT_W'(coin_value(coin_t'(i))) <= rem_q) begin
        found = 1'b1;
        pick  = coin_t'(i);
      end
    pay              = CREDIT_W'(coin_value(pick));
    coin_out_valid_o = active_i & found;
    coin_out_type_o  = coin_out_valid_o ? pick : 2'd0;
    short_o          = active_i & ~found & (rem_q != '0);
    done_o           = short_o | (coin_out_valid_o & (rem_q == pay)) | (active_i & (rem_q == '0));
    rem_d            = start_i ? amount_i : short_o ? '0 : coin_out_valid_o ? rem_q - pay : rem_q;
    for (int i = 0; i < 4; i++)
      tube_d[i] = tube_q[i] - TUBE_W'(coin_out_valid_o && pick == coin_t'(i))
                + TUBE_W'(dep_valid_i && dep_type_i == 2'(i) && tube_q[i] != TUBE_FULL);
  end
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rem_q <= '0;
      for (int i = 0; i < 4; i++) tube_q[i] <= TUBE_INIT;
    end else begin
      rem_q <= rem_d;
      for (int i = 0; i < 4; i++) tube_q[i] <= tube_d[i];
    end
  assign pending_o           = rem_q != '0;
  assign exact_change_only_o = (tube_q[NICKEL] < THRESH) || (tube_q[DIME] < THRESH);
endmodule

// File: rtl/vend_controller_mc.sv
// vend_controller_mc: multi-drink vending FSM with credit, exact-change mode and greedy change.
// Optional idle refund timeout enabled by defining VEND_TIMEOUT_EN.
module vend_controller_mc
  import vend_pkg::*;
#(
  parameter int N_DRINKS     = 6,
  parameter int PRICE_W      = 6,
  parameter int CREDIT_W     = 7,
  parameter int TUBE_W       = 4,
  parameter int INIT_TUBE    = 8,
  parameter int EXACT_THRESH = 2
`ifdef VEND_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         coin_valid_i,
  input  logic [1:0]                   coin_type_i,
  input  logic                         select_valid_i,
  input  logic [$clog2(N_DRINKS)-1:0]  select_id_i,
  input  logic [N_DRINKS*PRICE_W-1:0]  price_table_i,
  input  logic [N_DRINKS-1:0]          stock_ok_i,
  input  logic                         cancel_i,
  output logic [CREDIT_W-1:0]          credit_o,
  output logic                         vend_valid_o,
  output logic [$clog2(N_DRINKS)-1:0]  vend_id_o,
  output logic                         select_reject_o,
  output logic                         coin_return_o,
  output logic                         coin_out_valid_o,
  output logic [1:0]                   coin_out_type_o,
  output logic                         change_short_o,
  output logic                         busy_o,
  output logic                         exact_change_only_o
);
  localparam int ID_W = $clog2(N_DRINKS);
  localparam logic [CREDIT_W:0] CREDIT_MAX = (CREDIT_W+1)'((1 << CREDIT_W) - 1);
  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, price, amount;
  logic [ID_W-1:0]     vend_id_q, vend_id_d, sid;
  logic                ret_q, ret_d, rej_q, rej_d;
  logic                start, dep_valid, pending, done, id_ok, accept, cancel_eff;
  logic [CREDIT_W:0]   sum;
`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_q, idle_d;
  logic            timeout;
  assign timeout = state_q == IDLE && credit_q != '0 && !(coin_valid_i || select_valid_i || cancel_i)
                   && idle_q == TO_W'(TIMEOUT_CYCLES - 1);
  assign idle_d  = (state_q != IDLE || credit_q == '0 || coin_valid_i || select_valid_i || cancel_i || timeout)
                   ? '0 : idle_q + 1'b1;
  assign cancel_eff = cancel_i | timeout;
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) idle_q <= '0;
    else idle_q <= idle_d;
`else
  assign cancel_eff = cancel_i;
`endif
  assign id_ok  = int'(select_id_i) < N_DRINKS;
  assign sid    = id_ok ? select_id_i : '0;
  assign price  = CREDIT_W'(price_table_i[sid*PRICE_W +: PRICE_W]);
  assign accept = id_ok && stock_ok_i[sid] && credit_q >= price && (!exact_change_only_o || credit_q == price);
  assign sum    = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_t'(coin_type_i)));
  // in IDLE: cancel beats select beats coin; a coin that loses or arrives while busy bounces
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    vend_id_d = vend_id_q;
    ret_d     = coin_valid_i;
    rej_d     = 1'b0;
    start     = 1'b0;
    amount    = '0;
    dep_valid = 1'b0;
    case (state_q)
      IDLE:
        if (cancel_eff) begin
          start    = credit_q != '0;
          amount   = credit_q;
          credit_d = '0;
          state_d  = credit_q != '0 ? CHANGE : IDLE;
        end else if (select_valid_i) begin
          rej_d     = !accept;
          start     = accept;
          amount    = credit_q - price;
          credit_d  = accept ? '0 : credit_q;
          vend_id_d = accept ? select_id_i : vend_id_q;
          state_d   = accept ? VEND : IDLE;
        end else if (coin_valid_i) begin
          ret_d     = sum > CREDIT_MAX;
          dep_valid = sum <= CREDIT_MAX;
          credit_d  = sum <= CREDIT_MAX ? sum[CREDIT_W-1:0] : credit_q;
        end
      VEND:    state_d = pending ? CHANGE : IDLE;
      default: state_d = done ? IDLE : state_q;
    endcase
  end
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      vend_id_q <= '0;
      ret_q     <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      vend_id_q <= vend_id_d;
      ret_q     <= ret_d;
      rej_q     <= rej_d;
    end
  vend_change_dispenser #(
    .CREDIT_W(CREDIT_W), .TUBE_W(TUBE_W), .INIT_TUBE(INIT_TUBE), .EXACT_THRESH(EXACT_THRESH)
  ) u_disp (
    .clock_i(clock_i), .reset_n_i(reset_n_i),
    .start_i(start), .amount_i(amount), .active_i(state_q == CHANGE),
    .dep_valid_i(dep_valid), .dep_type_i(coin_type_i),
    .pending_o(pending), .coin_out_valid_o(coin_out_valid_o), .coin_out_type_o(coin_out_type_o),
    .done_o(done), .short_o(change_short_o), .exact_change_only_o(exact_change_only_o)
  );
  assign credit_o        = credit_q;
  assign vend_valid_o    = state_q == VEND;
  assign vend_id_o       = vend_id_q;
  assign select_reject_o = rej_q;
  assign coin_return_o   = ret_q;
  assign busy_o          = state_q != IDLE;
endmodule

// File: tb/tb_vend_controller_mc.sv
// tb_vend_controller_mc: directed and random transactions checked against a coin-level reference model
module tb_vend_controller_mc;
  localparam int N = 6, CMAX = 127, TMAX = 15, TINIT = 8, THR = 2;
  localparam int NI = 0, DI = 1, QU = 2, HA = 3;
  logic       clk = 0, rst_n = 0;
  logic       coin_valid = 0, select_valid = 0, cancel = 0;
  logic [1:0] coin_type = 0;
  logic [2:0] select_id = 0;
  logic [35:0] price_table;
  logic [5:0] stock_ok = 6'b101111;
  logic [6:0] credit;
  logic       vend_valid, select_reject, coin_return, coin_out_valid, change_short, busy, exact;
  logic [2:0] vend_id;
  logic [1:0] coin_out_type;
  int errors = 0, checks = 0;
  int prices[N] = '{2, 5, 10, 4, 7, 63};
  int val[4] = '{1, 2, 5, 10};
  int m_tube[4];
  int m_credit;
  int exp_n, got_n, e_id;
  longint exp_code, got_code;
  bit exp_short, got_short, got_to, short_with_coin, e_vend, e_rej, e_ret;
  logic s_vend, s_rej, s_ret;
  logic [2:0] s_id;
  logic [6:0] s_credit;

  vend_controller_mc dut (
    .clock_i(clk), .reset_n_i(rst_n), .coin_valid_i(coin_valid), .coin_type_i(coin_type),
    .select_valid_i(select_valid), .select_id_i(select_id), .price_table_i(price_table),
    .stock_ok_i(stock_ok), .cancel_i(cancel), .credit_o(credit), .vend_valid_o(vend_valid),
    .vend_id_o(vend_id), .select_reject_o(select_reject), .coin_return_o(coin_return),
    .coin_out_valid_o(coin_out_valid), .coin_out_type_o(coin_out_type),
    .change_short_o(change_short), .busy_o(busy), .exact_change_only_o(exact)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic bit m_exact();
    return m_tube[NI] < THR || m_tube[DI] < THR;
  endfunction

  // greedy payout from the model tubes; encodes the coin sequence as a base-7 code
  function automatic void m_change(int amt);
    int pick;
    while (amt > 0) begin
      pick = -1;
      for (int d = 3; d >= 0; d--) if (pick < 0 && m_tube[d] > 0 && val[d] <= amt) pick = d;
      if (pick < 0) begin
        exp_short = 1;
        amt = 0;
      end else begin
        m_tube[pick]--;
        amt -= val[pick];
        exp_n++;
        exp_code = exp_code * 7 + pick + 1;
      end
    end
  endfunction

  function automatic void m_op(bit cv, int ct, bit sv, int sid, bit cn);
    e_vend = 0; e_rej = 0; e_ret = 0; e_id = 0;
    exp_n = 0; exp_code = 0; exp_short = 0;
    if (cn) begin
      e_ret = cv;
      if (m_credit > 0) begin m_change(m_credit); m_credit = 0; end
    end else if (sv) begin
      e_ret = cv;
      if (sid < N && stock_ok[sid] && m_credit >= prices[sid] && (!m_exact() || m_credit == prices[sid])) begin
        e_vend = 1; e_id = sid;
        m_change(m_credit - prices[sid]);
        m_credit = 0;
      end else e_rej = 1;
    end else if (cv) begin
      if (m_credit + val[ct] > CMAX) e_ret = 1;
      else begin
        m_credit += val[ct];
        if (m_tube[ct] < TMAX) m_tube[ct]++;
      end
    end
  endfunction

  task automatic do_reset();
    coin_valid = 0; select_valid = 0; cancel = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) m_tube[i] = TINIT;
    m_credit = 0;
  endtask

  task automatic op(bit cv, int ct, bit sv, int sid, bit cn);
    coin_valid = cv; coin_type = ct[1:0]; select_valid = sv; select_id = sid[2:0]; cancel = cn;
    @(posedge clk); #1;
    coin_valid = 0; select_valid = 0; cancel = 0;
    s_vend = vend_valid; s_id = vend_id; s_rej = select_reject; s_ret = coin_return; s_credit = credit;
  endtask

  task automatic collect();
    got_n = 0; got_code = 0; got_short = 0; got_to = 0; short_with_coin = 0;
    for (int k = 0; k < 100 && busy; k++) begin
      if (coin_out_valid) begin got_n++; got_code = got_code * 7 + coin_out_type + 1; end
      if (change_short) begin got_short = 1; if (coin_out_valid) short_with_coin = 1; end
      @(posedge clk); #1;
    end
    if (busy) got_to = 1;
  endtask

  task automatic xact(bit cv, int ct, bit sv, int sid, bit cn);
    m_op(cv, ct, sv, sid, cn);
    op(cv, ct, sv, sid, cn);
    collect();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({credit, vend_valid, vend_id, select_reject, coin_return, coin_out_valid, coin_out_type, change_short, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0", {credit, vend_valid, vend_id, select_reject, coin_return, coin_out_valid, coin_out_type, change_short, busy}); end
    checks++; if (exact !== 1'b0) begin errors++; $display("FAIL reset_exact: got %b exp 0", exact); end
  endtask

  task automatic test_vend_change();
    do_reset();
    xact(1, QU, 0, 0, 0); xact(1, QU, 0, 0, 0); xact(1, DI, 0, 0, 0);
    checks++; if (s_credit !== 7'(m_credit)) begin errors++; $display("FAIL vc_credit: got %0d exp %0d", s_credit, m_credit); end
    xact(0, 0, 1, 2, 0);
    checks++; if (s_vend !== 1'b1 || s_id !== 3'd2) begin errors++; $display("FAIL vc_vend: got v=%b id=%0d exp v=1 id=2", s_vend, s_id); end
    checks++; if (s_credit !== 7'd0) begin errors++; $display("FAIL vc_credit_clr: got %0d exp 0", s_credit); end
    checks++; if (got_n !== exp_n || got_code !== exp_code || got_to) begin
      errors++; $display("FAIL vc_change: got n=%0d code=%0d exp n=%0d code=%0d", got_n, got_code, exp_n, exp_code); end
    checks++; if (busy !== 1'b0 || credit !== 7'd0) begin errors++; $display("FAIL vc_idle: got busy=%b credit=%0d exp 0 0", busy, credit); end
  endtask

  task automatic test_reject_cancel();
    do_reset();
    xact(1, DI, 0, 0, 0); xact(1, DI, 0, 0, 0);
    xact(0, 0, 1, 1, 0);
    checks++; if (s_rej !== 1'b1 || s_vend !== 1'b0) begin errors++; $display("FAIL rc_reject: got rej=%b vend=%b exp 1 0", s_rej, s_vend); end
    checks++; if (s_credit !== 7'(m_credit)) begin errors++; $display("FAIL rc_credit: got %0d exp %0d", s_credit, m_credit); end
    xact(0, 0, 0, 0, 1);
    checks++; if (got_n !== exp_n || got_code !== exp_code) begin
      errors++; $display("FAIL rc_refund: got n=%0d code=%0d exp n=%0d code=%0d", got_n, got_code, exp_n, exp_code); end
  endtask

  task automatic test_exact_change();
    do_reset();
    for (int i = 0; i < 7; i++) begin xact(1, HA, 0, 0, 0); xact(0, 0, 1, 0, 0); end
    checks++; if (exact !== m_exact()) begin errors++; $display("FAIL ex_flag: got %b exp %b", exact, m_exact()); end
    xact(1, HA, 0, 0, 0); xact(1, DI, 0, 0, 0);
    xact(0, 0, 1, 2, 0);
    checks++; if (s_rej !== e_rej || s_vend !== e_vend) begin errors++; $display("FAIL ex_reject: got rej=%b vend=%b exp %b %b", s_rej, s_vend, e_rej, e_vend); end
    xact(0, 0, 0, 0, 1);
    checks++; if (got_code !== exp_code) begin errors++; $display("FAIL ex_refund: got %0d exp %0d", got_code, exp_code); end
    xact(1, HA, 0, 0, 0);
    xact(0, 0, 1, 2, 0);
    checks++; if (s_vend !== e_vend || got_n !== exp_n) begin errors++; $display("FAIL ex_exact_vend: got vend=%b n=%0d exp %b %0d", s_vend, got_n, e_vend, exp_n); end
  endtask

  task automatic test_credit_sat();
    do_reset();
    for (int i = 0; i < 12; i++) xact(1, HA, 0, 0, 0);
    xact(1, QU, 0, 0, 0);
    checks++; if (s_credit !== 7'(m_credit)) begin errors++; $display("FAIL cs_build: got %0d exp %0d", s_credit, m_credit); end
    xact(1, QU, 0, 0, 0);
    checks++; if (s_ret !== e_ret || s_credit !== 7'(m_credit)) begin errors++; $display("FAIL cs_overflow: got ret=%b credit=%0d exp %b %0d", s_ret, s_credit, e_ret, m_credit); end
    xact(1, DI, 0, 0, 0);
    checks++; if (s_ret !== e_ret || s_credit !== 7'(m_credit)) begin errors++; $display("FAIL cs_max: got ret=%b credit=%0d exp %b %0d", s_ret, s_credit, e_ret, m_credit); end
    xact(1, NI, 0, 0, 0);
    checks++; if (s_ret !== e_ret) begin errors++; $display("FAIL cs_full: got ret=%b exp %b", s_ret, e_ret); end
    xact(0, 0, 0, 0, 1);
    checks++; if (got_code !== exp_code || got_short !== exp_short) begin errors++; $display("FAIL cs_refund: got %0d/%b exp %0d/%b", got_code, got_short, exp_code, exp_short); end
  endtask

  task automatic test_short();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      xact(1, DI, 0, 0, 0); xact(1, DI, 0, 0, 0); xact(1, DI, 0, 0, 0); xact(0, 0, 0, 0, 1);
    end
    xact(1, QU, 0, 0, 0); xact(1, DI, 0, 0, 0); xact(1, DI, 0, 0, 0); xact(1, DI, 0, 0, 0);
    xact(0, 0, 0, 0, 1);
    checks++; if (got_short !== exp_short || short_with_coin) begin errors++; $display("FAIL sh_pulse: got %b coin=%b exp %b", got_short, short_with_coin, exp_short); end
    checks++; if (got_code !== exp_code || got_n !== exp_n) begin errors++; $display("FAIL sh_coins: got %0d exp %0d", got_code, exp_code); end
    checks++; if (busy !== 1'b0 || credit !== 7'd0 || got_to) begin errors++; $display("FAIL sh_idle: got busy=%b credit=%0d exp 0 0", busy, credit); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    xact(1, QU, 0, 0, 0); xact(1, QU, 0, 0, 0);
    m_op(1, DI, 1, 3, 0);
    op(1, DI, 1, 3, 0);
    checks++; if (s_vend !== 1'b1 || s_id !== 3'd3 || s_ret !== 1'b1) begin errors++; $display("FAIL bb_vend_ret: got v=%b id=%0d ret=%b exp 1 3 1", s_vend, s_id, s_ret); end
    op(1, NI, 1, 0, 0);
    checks++; if (s_ret !== 1'b1 || s_rej !== 1'b0) begin errors++; $display("FAIL bb_busy: got ret=%b rej=%b exp 1 0", s_ret, s_rej); end
    collect();
    checks++; if (got_code !== exp_code || got_n !== exp_n) begin errors++; $display("FAIL bb_change: got %0d exp %0d", got_code, exp_code); end
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    xact(1, QU, 0, 0, 0); xact(1, QU, 0, 0, 0);
    m_op(0, 0, 1, 3, 0);
    op(0, 0, 1, 3, 0);
    op(0, 0, 0, 0, 0);
    checks++; if (coin_out_valid !== 1'b1 || coin_out_type !== 2'(QU)) begin errors++; $display("FAIL rm_first: got %b/%0d exp 1/%0d", coin_out_valid, coin_out_type, QU); end
    rst_n = 0;
    #2;
    checks++; if ({credit, vend_valid, vend_id, select_reject, coin_return, coin_out_valid, coin_out_type, change_short, busy, exact} !== '0) begin
      errors++; $display("FAIL rm_outputs: got %h exp 0", {credit, vend_valid, vend_id, select_reject, coin_return, coin_out_valid, coin_out_type, change_short, busy, exact}); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dut.u_disp.tube_q[i] !== 4'(TINIT)) begin errors++; $display("FAIL rm_tube%0d: got %0d exp %0d", i, dut.u_disp.tube_q[i], TINIT); end
    end
    do_reset();
  endtask

  task automatic test_random();
    bit cv, sv, cn;
    int ct, sid;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      cv = $urandom_range(0, 99) < 55; sv = $urandom_range(0, 99) < 25; cn = $urandom_range(0, 99) < 6;
      ct = $urandom_range(0, 3); sid = $urandom_range(0, 7);
      xact(cv, ct, sv, sid, cn);
      checks++; if (s_vend !== e_vend || (e_vend && s_id !== 3'(e_id))) begin errors++; $display("FAIL rnd_vend[%0d]: got %b/%0d exp %b/%0d", n, s_vend, s_id, e_vend, e_id); end
      checks++; if (s_rej !== e_rej) begin errors++; $display("FAIL rnd_reject[%0d]: got %b exp %b", n, s_rej, e_rej); end
      checks++; if (s_ret !== e_ret) begin errors++; $display("FAIL rnd_return[%0d]: got %b exp %b", n, s_ret, e_ret); end
      checks++; if (s_credit !== 7'(m_credit)) begin errors++; $display("FAIL rnd_credit[%0d]: got %0d exp %0d", n, s_credit, m_credit); end
      checks++; if (got_n !== exp_n || got_code !== exp_code || got_short !== exp_short || got_to) begin
        errors++; $display("FAIL rnd_change[%0d]: got n=%0d code=%0d short=%b exp n=%0d code=%0d short=%b", n, got_n, got_code, got_short, exp_n, exp_code, exp_short); end
      checks++; if (exact !== m_exact()) begin errors++; $display("FAIL rnd_exact[%0d]: got %b exp %b", n, exact, m_exact()); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) price_table[i*6 +: 6] = 6'(prices[i]);
    test_reset();
    test_vend_change();
    test_reject_cancel();
    test_exact_change();
    test_credit_sat();
    test_short();
    test_back_to_back();
    test_reset_mid_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vend_controller_mc.md
Name: vend_controller_mc

Overview:
- Parametrised next-generation vending controller: multi-drink selection, coin credit accumulation and greedy change dispensing, merged into one clocked FSM.
- Sits between the coin acceptor front end and the drink/coin-ejector actuators.
- Adds behaviour not present before:
  - N selectable drinks with a per-drink price table.
  - Coin-tube inventory tracking.
  - Automatic exact-change-only mode.
  - Cancel/refund.
  - Credit saturation.
- All money values are in nickel units (nickel=1, dime=2, quarter=5, half=10).

Parameters:
- N_DRINKS, 6, number of selectable drinks (>=2)
- PRICE_W, 6, width of each price entry in nickel units
- CREDIT_W, 7, credit register width; CREDIT_MAX = 2**CREDIT_W-1
- TUBE_W, 4, width of each coin-tube counter; tube full at 2**TUBE_W-1
- INIT_TUBE, 8, per-denomination tube count loaded at reset
- EXACT_THRESH, 2, exact_change_only asserts while nickel_cnt < EXACT_THRESH or dime_cnt < EXACT_THRESH

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- coin_valid  in  1  one-cycle pulse: coin inserted
- coin_type  in  2  0 nickel, 1 dime, 2 quarter, 3 half
- select_valid  in  1  one-cycle pulse: drink selected
- select_id  in  $clog2(N_DRINKS)  drink index
- price_table  in  N_DRINKS*PRICE_W  price of drink i at [i*PRICE_W +: PRICE_W]
- stock_ok  in  N_DRINKS  bit i = drink i in stock
- cancel  in  1  one-cycle pulse: refund all credit
- credit  out  CREDIT_W  current credit
- vend_valid  out  1  one-cycle pulse: dispense drink vend_id
- vend_id  out  $clog2(N_DRINKS)  drink being dispensed
- select_reject  out  1  one-cycle pulse: selection refused
- coin_return  out  1  one-cycle pulse: inserted coin bounced uncredited
- coin_out_valid  out  1  one coin ejected this cycle
- coin_out_type  out  2  denomination ejected
- change_short  out  1  one-cycle pulse: change could not be fully paid
- busy  out  1  high in VEND and CHANGE
- exact_change_only  out  1  combinational from tube counts

Behaviour:
- Reset (async, reset_n low):
  - State IDLE, credit=0.
  - All pulse outputs 0, vend_id=0, coin_out_type=0.
  - All four tube counters = INIT_TUBE.
  - Reset mid-CHANGE abandons the remaining change with no pulse.
- States and transitions:
  - IDLE: accept coins, cancel and selects.
  - VEND: exactly one cycle; vend_valid=1.
  - CHANGE: one coin per cycle while remaining>0.
  - IDLE <- CHANGE when remaining==0.
- Coin handling, IDLE only:
  - coin_valid at edge t -> credit += value visible at t+1; the tube counter for that type increments, saturating when full (overflow goes to cashbox but is still credited).
  - If credit+value > CREDIT_MAX: coin_return=1 at t+1, credit and tube unchanged.
  - Any coin_valid while busy -> coin_return.
- Select handling, IDLE only:
  - Accepted iff stock_ok[select_id]=1, credit >= price, and (exact_change_only=0 or credit==price).
  - Accepted at edge t: VEND at t+1 with vend_id latched; remaining = credit-price; credit cleared to 0 at t+1.
  - CHANGE entered at t+2 if remaining>0, else IDLE.
  - Refused: select_reject=1 at t+1, credit unchanged.
  - select_id >= N_DRINKS is refused.
  - select_valid while busy is ignored, no reject.
- Cancel, IDLE only:
  - With credit>0: remaining = credit, credit=0, go to CHANGE at t+1.
  - With credit==0: no-op.
- Same-cycle priority in IDLE: cancel > select > coin. The losing coin is bounced via coin_return; the losing select is ignored.
- CHANGE, greedy:
  - Each cycle, pick the largest denomination with value <= remaining and tube count > 0.
  - Assert coin_out_valid/coin_out_type, decrement that tube, subtract its value.
  - If no denomination qualifies while remaining>0: change_short=1 for one cycle, remaining discarded, return to IDLE.
- Widths: remaining uses CREDIT_W; price is zero-extended to CREDIT_W; subtraction never underflows (guarded by the accept rule).

Optional Feature:
- Macro: VEND_TIMEOUT_EN
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 1000) and an internal idle counter, reset on any coin, select or cancel.
  - In IDLE with credit>0, the counter reaching TIMEOUT_CYCLES-1 triggers an automatic cancel (refund via CHANGE) on the next cycle.
- Undefined: credit is held indefinitely; no counter logic is present.

Decomposition:
- Package vend_pkg: coin_t enum (NICKEL, DIME, QUARTER, HALF), coin value constants in nickel units, state_t enum (IDLE, VEND, CHANGE), function coin_value(coin_t).
- Sub-module vend_change_dispenser: owns the four tube counters, the greedy selector and the remaining-change register.
  - Interface: start/amount in, coin_out_valid/type out, done and short out, deposit port for inserted coins.

Test Plan:
- Insert quarter, quarter, dime (credit 12); select drink 2 with price 10, stock ok -> vend_valid with vend_id=2, then exactly one DIME out, back to IDLE with credit 0.
- Credit 4 (two dimes); select drink with price 5 -> select_reject, credit stays 4; cancel -> two DIME pulses.
- Force nickel and dime tubes below EXACT_THRESH with credit 12, price 10 -> exact_change_only=1, select_reject; credit exactly 10, price 10 -> vend, no change.
- Credit CREDIT_MAX-2 (125 with defaults); insert quarter -> coin_return, credit unchanged.
- Empty nickel tube, remaining change 1 -> change_short pulse, IDLE, no coin out.
- Coin and select in the same IDLE cycle, credit sufficient -> vend, coin_return; assert reset_n low mid-CHANGE -> all outputs at reset values, tubes = INIT_TUBE.
